// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the register-file FIFO controller: default widths,
// output-queue state encoding and the occupancy helper used by the issue rule.
package fifo_ctrl_pkg;

    localparam int FIFO_DW = 32;
    localparam int FIFO_AW = 3;

    // Output-queue state doubles as its word count.
    typedef enum logic [1:0] {
        OQ_EMPTY = 2'd0,
        OQ_ONE   = 2'd1,
        OQ_TWO   = 2'd2
    } oq_state_e;

    // Words held or landing in the output queue after this edge, before any new issue.
    function automatic logic [2:0] oq_occupancy(input logic [1:0] cnt, input logic pend,
                                                input logic pop);
        return {1'b0, cnt} + {2'b00, pend} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fifo_ctrl_oq.sv
// Two-entry output queue: head drives out_data, skid absorbs the read that was
// already in flight when the consumer stalled.
module fifo_ctrl_oq
    import fifo_ctrl_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          valid,
    output oq_state_e     state
);

    logic [DW-1:0] skid;

    assign valid = (state != OQ_EMPTY);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= OQ_EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                OQ_EMPTY: begin
                    if (load) begin
                        head  <= load_data;
                        state <= OQ_ONE;
                    end
                end
                OQ_ONE: begin
                    if (load && pop) begin
                        head <= load_data;
                    end else if (load) begin
                        skid  <= load_data;
                        state <= OQ_TWO;
                    end else if (pop) begin
                        // head keeps its stale word; consumers ignore it while empty
                        state <= OQ_EMPTY;
                    end
                end
                OQ_TWO: begin
                    if (pop) begin
                        head <= skid;
                        if (load) begin
                            skid <= load_data;
                        end else begin
                            state <= OQ_ONE;
                        end
                    end
                end
                default: state <= OQ_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO sequencer for a synchronous-read register file: pointers, occupancy and
// read issue live here; the output queue hides the one-cycle read latency.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int DW = FIFO_DW,
    parameter int AW = FIFO_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          rf_wr_en,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_wr_data,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_rdata,
    output logic [AW:0]   rf_count
);

    localparam int         DEPTH      = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          rd_pend;
    logic          push;
    logic          pop;
    logic          issue;
    logic [2:0]    occ_after;
    oq_state_e     oq_state;

    // Handshakes: a word moves on an edge where valid & ready are both high; valid never
    // waits on ready, and in_ready depends on registered state only.
    assign in_ready   = (count != FULL_COUNT);
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;
    assign rf_wr_en   = push;
    assign rf_wr_addr = wr_ptr;
    assign rf_wr_data = in_data;
    assign rf_rd_addr = rd_ptr;
    assign rf_count   = count;

    // Only words already counted are read, so a same-edge write to rd_ptr is never fetched.
    assign occ_after = oq_occupancy(oq_state, rd_pend, pop);
    assign issue     = (count != '0) && (occ_after < 3'd2);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_pend <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (issue) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_pend <= issue;
            count   <= count + (AW+1)'(push) - (AW+1)'(issue);
        end
    end

    fifo_ctrl_oq #(.DW(DW)) u_oq (
        .clk       (clk),
        .clr       (rst | flush),
        .load      (rd_pend),
        .load_data (rf_rdata),
        .pop       (pop),
        .head      (out_data),
        .valid     (out_valid),
        .state     (oq_state)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with a behavioural 8x32 synchronous-read register file.
module tb_fifo_ctrl;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_rdata;
    logic [AW:0]   rf_count;

    logic [DW-1:0] rf_mem [8];

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic        iv;
        logic [31:0] data;
        logic        ordy;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic        exp_ir;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
        rf_rdata <= rf_mem[rf_rd_addr];
    end

    fifo_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data),
        .rf_rd_addr (rf_rd_addr),
        .rf_rdata   (rf_rdata),
        .rf_count   (rf_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard sample mid-cycle, then advance to just after the next rising edge.
    task automatic tick();
        logic [DW-1:0] exp;
        @(negedge clk);
        if (out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got 0x%0h, expected no word", out_data);
            end else begin
                exp = exp_q.pop_front();
                if (out_data !== exp) begin
                    n_bad++;
                    $display("FAIL sb_data: got 0x%0h, expected 0x%0h", out_data, exp);
                end
            end
        end
        if (rst || flush) exp_q.delete();
        else if (in_valid && in_ready) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) tick();
        tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        check("drain_count", 32'(rf_count), 32'd0);
    endtask

    initial begin
        int accepted;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_rf_count", 32'(rf_count), 32'd0);
        check("rst_out_data", out_data, 32'd0);

        // Reset mid-stream with five words held
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h100 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("t1_out_valid", 32'(out_valid), 32'd0);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        check("t1_rf_count", 32'(rf_count), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_no_old_word", 32'(out_valid), 32'd0);
        end

        // Single-word latency, table-driven
        vecs[0] = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b0, 32'h0,         1'b1, 4'd1};
        vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 4'd0};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 4'd0};
        vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b1, 4'd0};
        for (int v = 0; v < 4; v++) begin
            in_valid  = vecs[v].iv;
            in_data   = vecs[v].data;
            out_ready = vecs[v].ordy;
            #1;
            check($sformatf("t2_wr_en[%0d]", v), 32'(rf_wr_en), 32'(vecs[v].iv));
            tick();
            check($sformatf("t2_out_valid[%0d]", v), 32'(out_valid), 32'(vecs[v].exp_ov));
            check($sformatf("t2_in_ready[%0d]", v), 32'(in_ready), 32'(vecs[v].exp_ir));
            check($sformatf("t2_rf_count[%0d]", v), 32'(rf_count), 32'(vecs[v].exp_cnt));
            if (vecs[v].exp_ov) check($sformatf("t2_out_data[%0d]", v), out_data, vecs[v].exp_od);
        end

        // Continuous stream at one word per clock
        out_ready = 1'b1;
        for (int t = 0; t < 22; t++) begin
            if (t < 20) begin
                in_valid = 1'b1;
                in_data  = 32'(t);
                check("t3_in_ready", 32'(in_ready), 32'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (t >= 2) begin
                check("t3_out_valid", 32'(out_valid), 32'd1);
                check("t3_out_data", out_data, 32'(t - 2));
            end
        end
        in_valid = 1'b0;
        wait_drain(10);

        // Fill to capacity with the consumer stalled
        out_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 14; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h4000 + 32'(i);
            if (in_ready) accepted++;
            tick();
        end
        in_valid = 1'b0;
        check("t4_accepted", 32'(accepted), 32'd10);
        check("t4_rf_count", 32'(rf_count), 32'd8);
        check("t4_in_ready_full", 32'(in_ready), 32'd0);
        check("t4_out_data", out_data, 32'h4000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_stall_stable", out_data, 32'h4000);
        end
        out_ready = 1'b1;
        check("t4_in_ready_at_pop", 32'(in_ready), 32'd0);
        tick();
        out_ready = 1'b0;
        check("t4_in_ready_after_pop", 32'(in_ready), 32'd1);
        check("t4_rf_count_after_pop", 32'(rf_count), 32'd7);
        tick();
        check("t4_head_after_pop", out_data, 32'h4001);
        out_ready = 1'b1;
        wait_drain(20);

        // Pointer wrap: advance both pointers to 6, then fill across 7 -> 0
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h5000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        wait_drain(10);
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h5100 + 32'($urandom_range(0, 255)) * 32'h10000 + 32'(i);
            #1;
            if (i < 8) check("t5_wr_addr", 32'(rf_wr_addr), 32'((6 + i) % 8));
            tick();
        end
        in_valid = 1'b0;
        check("t5_rf_count", 32'(rf_count), 32'd8);
        check("t5_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        wait_drain(20);

        // Flush with a push, a pop and a read in flight on the same clock
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h7000 + 32'(i);
            tick();
        end
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        check("t6_pre_data", out_data, 32'h7000);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_rf_count", 32'(rf_count), 32'd0);
        check("t6_out_data", out_data, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_stays_empty", 32'(out_valid), 32'd0);
        end
        in_valid = 1'b1;
        in_data  = 32'h6000_0001;
        tick();
        in_valid = 1'b0;
        wait_drain(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
